// File: rtl/term_writer.sv
// Terminal character engine: turns a byte stream into screen RAM writes,
// cursor moves, and scroll/clear blit requests for the text-mode display.
module term_writer #(
  parameter int COLS     = 80,
  parameter int ROWS     = 25,
  parameter int TAB_W    = 8,
  parameter int RST_WAIT = 8191
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        blit_en,
  output logic [10:0] blit_start,
  output logic [10:0] blit_end,
  output logic [7:0]  blit_offset,
  input  logic        blit_complete,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  typedef enum logic [2:0] {
    RST_HOLD, IDLE, WRITE, SCROLL_COPY, SCROLL_CLEAR, CLEAR, BLIT_WAIT
  } state_t;

  localparam logic [10:0] COLS_A        = 11'(COLS);
  localparam logic [10:0] LAST_ROW_BASE = 11'((ROWS - 1) * COLS);
  localparam logic [10:0] CELLS         = 11'(ROWS * COLS);
  localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
  localparam logic [7:0]  SCROLL_OFS    = 8'(COLS - 1);
  localparam logic [7:0]  TAB_MASK      = 8'(TAB_W - 1);
  localparam logic [15:0] WAIT_INIT     = 16'(RST_WAIT);

  state_t      state_reg, state_next;
  logic [15:0] wait_reg, wait_next;
  logic        after_copy_reg, after_copy_next;
  logic        scroll_pend_reg, scroll_pend_next;
  logic [6:0]  col_reg, col_next;
  logic [4:0]  row_reg, row_next;
  logic        wr_en_reg, wr_en_next;
  logic [10:0] wr_addr_reg, wr_addr_next;
  logic [7:0]  wr_data_reg, wr_data_next;
  logic        blit_en_reg, blit_en_next;
  logic [10:0] blit_start_reg, blit_start_next;
  logic [10:0] blit_end_reg, blit_end_next;
  logic [7:0]  blit_offset_reg, blit_offset_next;

  logic [10:0] cell_addr;
  logic [7:0]  tab_col;

  assign cell_addr = 11'(row_reg) * COLS_A + 11'(col_reg);
  assign tab_col   = (8'(col_reg) | TAB_MASK) + 8'd1;

  always_comb begin
    state_next       = state_reg;
    wait_next        = wait_reg;
    after_copy_next  = after_copy_reg;
    scroll_pend_next = scroll_pend_reg;
    col_next         = col_reg;
    row_next         = row_reg;
    wr_en_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    blit_en_next     = 1'b0;
    blit_start_next  = blit_start_reg;
    blit_end_next    = blit_end_reg;
    blit_offset_next = blit_offset_reg;

    case (state_reg)
      RST_HOLD: begin
        if (wait_reg <= 16'd1) state_next = IDLE;
        else                   wait_next  = wait_reg - 16'd1;
      end
      IDLE: begin
        if (rx_valid) begin
          state_next       = WRITE;
          scroll_pend_next = 1'b0;
          if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            wr_en_next   = 1'b1;
            wr_addr_next = cell_addr;
            wr_data_next = rx_data;
            if (col_reg == LAST_COL) begin
              col_next = 7'd0;
              // Wrapping off the bottom row: the write goes out first, the scroll follows.
              if (row_reg == LAST_ROW) scroll_pend_next = 1'b1;
              else                     row_next = row_reg + 5'd1;
            end else begin
              col_next = col_reg + 7'd1;
            end
          end else begin
            case (rx_data)
              8'h0D: col_next = 7'd0;
              8'h0A: begin
                if (row_reg == LAST_ROW) begin
                  state_next       = SCROLL_COPY;
                  blit_en_next     = 1'b1;
                  blit_start_next  = 11'd0;
                  blit_end_next    = LAST_ROW_BASE;
                  blit_offset_next = SCROLL_OFS;
                  after_copy_next  = 1'b1;
                end else begin
                  row_next = row_reg + 5'd1;
                end
              end
              8'h08: if (col_reg != 7'd0) col_next = col_reg - 7'd1;
              8'h09: col_next = (tab_col > 8'(LAST_COL)) ? LAST_COL : tab_col[6:0];
              8'h0C: begin
                col_next         = 7'd0;
                row_next         = 5'd0;
                state_next       = CLEAR;
                blit_en_next     = 1'b1;
                blit_start_next  = 11'd0;
                blit_end_next    = CELLS;
                blit_offset_next = 8'd0;
                after_copy_next  = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (scroll_pend_reg) begin
          state_next       = SCROLL_COPY;
          blit_en_next     = 1'b1;
          blit_start_next  = 11'd0;
          blit_end_next    = LAST_ROW_BASE;
          blit_offset_next = SCROLL_OFS;
          after_copy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SCROLL_COPY, SCROLL_CLEAR, CLEAR: state_next = BLIT_WAIT;
      BLIT_WAIT: begin
        if (blit_complete) begin
          if (after_copy_reg) begin
            state_next       = SCROLL_CLEAR;
            blit_en_next     = 1'b1;
            blit_start_next  = LAST_ROW_BASE;
            blit_end_next    = CELLS;
            blit_offset_next = 8'd0;
            after_copy_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_reg       <= RST_HOLD;
      wait_reg        <= WAIT_INIT;
      after_copy_reg  <= 1'b0;
      scroll_pend_reg <= 1'b0;
      col_reg         <= 7'd0;
      row_reg         <= 5'd0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= 11'd0;
      wr_data_reg     <= 8'd0;
      blit_en_reg     <= 1'b0;
      blit_start_reg  <= 11'd0;
      blit_end_reg    <= 11'd0;
      blit_offset_reg <= 8'd0;
    end else begin
      state_reg       <= state_next;
      wait_reg        <= wait_next;
      after_copy_reg  <= after_copy_next;
      scroll_pend_reg <= scroll_pend_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      wr_en_reg       <= wr_en_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      blit_en_reg     <= blit_en_next;
      blit_start_reg  <= blit_start_next;
      blit_end_reg    <= blit_end_next;
      blit_offset_reg <= blit_offset_next;
    end
  end

  assign rx_ready    = (state_reg == IDLE);
  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign blit_en     = blit_en_reg;
  assign blit_start  = blit_start_reg;
  assign blit_end    = blit_end_reg;
  assign blit_offset = blit_offset_reg;
  assign cursor_col  = col_reg;
  assign cursor_row  = row_reg;

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: a per-byte action-script model checked every cycle,
// plus hand-computed expectations for the key terminal scenarios.
module tb_term_writer;

  localparam int COLS      = 80;
  localparam int ROWS      = 25;
  localparam int TAB_W     = 8;
  localparam int RST_WAIT  = 8191;
  localparam int CELLS     = COLS * ROWS;
  localparam int LAST_BASE = (ROWS - 1) * COLS;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        blit_complete = 1'b0;
  logic        rx_ready, wr_en, blit_en;
  logic [10:0] wr_addr, blit_start, blit_end;
  logic [7:0]  wr_data, blit_offset;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  term_writer #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W), .RST_WAIT(RST_WAIT)) dut (
    .clk100(clk100), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blit_en(blit_en), .blit_start(blit_start), .blit_end(blit_end),
    .blit_offset(blit_offset), .blit_complete(blit_complete),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  initial forever #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_fail = 0;
  bit done = 1'b0;

  task automatic finish_test();
    if (!done) begin
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      if (n_fail >= 200) finish_test();
    end
  endtask

  // Model: each accepted byte expands into a script of visible steps, one per cycle;
  // a WAIT step holds until the display acknowledges the blit.
  typedef enum {K_NOP, K_WR, K_BLIT, K_WAIT} kind_t;
  typedef struct { kind_t kind; int a; int b; int c; } step_t;
  step_t q[$];

  int m_col = 0, m_row = 0, m_hold = 0;
  bit m_live = 1'b0, m_ready = 1'b0, m_wr_en = 1'b0, m_blit_en = 1'b0;
  int m_wr_addr = 0, m_wr_data = 0, m_bs = 0, m_be = 0, m_bo = 0;

  task automatic push(input kind_t k, input int a, input int b, input int c);
    step_t s;
    s.kind = k; s.a = a; s.b = b; s.c = c;
    q.push_back(s);
  endtask

  task automatic model_accept(input int b);
    bit scroll;
    scroll = 1'b0;
    if (b >= 'h20 && b <= 'h7E) begin
      push(K_WR, m_row * COLS + m_col, b, 0);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        if (m_row < ROWS - 1) m_row++; else scroll = 1'b1;
      end
    end else if (b == 'h0A) begin
      if (m_row < ROWS - 1) m_row++; else scroll = 1'b1;
    end else if (b == 'h0D) begin
      m_col = 0;
    end else if (b == 'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 'h09) begin
      m_col = (m_col | (TAB_W - 1)) + 1;
      if (m_col > COLS - 1) m_col = COLS - 1;
    end else if (b == 'h0C) begin
      m_col = 0; m_row = 0;
      push(K_BLIT, 0, CELLS, 0);
      push(K_WAIT, 0, 0, 0);
    end
    if (scroll) begin
      push(K_BLIT, 0, LAST_BASE, COLS - 1);
      push(K_WAIT, 0, 0, 0);
      push(K_BLIT, LAST_BASE, CELLS, 0);
      push(K_WAIT, 0, 0, 0);
    end
    if (q.size() == 0) push(K_NOP, 0, 0, 0);
  endtask

  task automatic emit(output bit emitted);
    step_t s;
    s = q.pop_front();
    emitted = 1'b1;
    case (s.kind)
      K_WR:   begin m_wr_en = 1'b1; m_wr_addr = s.a; m_wr_data = s.b; end
      K_BLIT: begin m_blit_en = 1'b1; m_bs = s.a; m_be = s.b; m_bo = s.c; end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    bit prev_blit, emitted;
    prev_blit = m_blit_en;
    emitted   = 1'b0;
    m_wr_en   = 1'b0;
    m_blit_en = 1'b0;
    if (rst) begin
      m_live = 1'b1; q.delete(); m_hold = RST_WAIT;
      m_col = 0; m_row = 0; m_wr_addr = 0; m_wr_data = 0;
      m_bs = 0; m_be = 0; m_bo = 0; m_ready = 1'b0;
      return;
    end
    if (!m_live) return;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_ready && rx_valid) begin
      model_accept(int'(rx_data));
      emit(emitted);
    end else if (q.size() > 0) begin
      // An acknowledge arriving in the request cycle itself is not a completion.
      if (q[0].kind == K_WAIT) begin
        if (blit_complete && !prev_blit) begin
          void'(q.pop_front());
          if (q.size() > 0) emit(emitted);
        end
      end else begin
        emit(emitted);
      end
    end
    m_ready = (m_hold == 0) && (q.size() == 0) && !emitted;
  endtask

  initial forever begin
    @(posedge clk100);
    model_edge();
  end

  int wr_cnt = 0, last_wr_addr = 0, last_wr_data = 0;
  int blit_cnt = 0, lb_s = 0, lb_e = 0, lb_o = 0, pb_s = 0, pb_e = 0, pb_o = 0;

  initial forever begin
    @(negedge clk100);
    if (m_live && !done) begin
      check("rx_ready", rx_ready, m_ready);
      check("wr_en", wr_en, m_wr_en);
      check("blit_en", blit_en, m_blit_en);
      if (m_wr_en || m_hold > 0) begin
        check("wr_addr", wr_addr, m_wr_addr);
        check("wr_data", wr_data, m_wr_data);
      end
      check("blit_start", blit_start, m_bs);
      check("blit_end", blit_end, m_be);
      check("blit_offset", blit_offset, m_bo);
      check("cursor_col", cursor_col, m_col);
      check("cursor_row", cursor_row, m_row);
      if (wr_en) begin
        wr_cnt++; last_wr_addr = wr_addr; last_wr_data = wr_data;
      end
      if (blit_en) begin
        blit_cnt++;
        pb_s = lb_s; pb_e = lb_e; pb_o = lb_o;
        lb_s = blit_start; lb_e = blit_end; lb_o = blit_offset;
      end
    end
  end

  // Display stand-in: acknowledges each blit after a short random delay.
  bit auto_cpl = 1'b1, spurious = 1'b0, cpl_pend = 1'b0;
  int cpl_dly = 0;
  initial forever begin
    @(negedge clk100);
    blit_complete = 1'b0;
    if (rst) begin
      cpl_pend = 1'b0;
    end else if (blit_en && auto_cpl) begin
      cpl_pend = 1'b1;
      cpl_dly  = $urandom_range(0, 6);
      if (spurious && $urandom_range(0, 3) == 0) blit_complete = 1'b1;
    end else if (cpl_pend) begin
      if (cpl_dly == 0) begin blit_complete = 1'b1; cpl_pend = 1'b0; end
      else cpl_dly--;
    end else if (spurious && $urandom_range(0, 19) == 0) begin
      blit_complete = 1'b1;
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!rx_ready && n < 20000) begin @(negedge clk100); n++; end
    if (n >= 20000) check(name, rx_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready("send_ready_timeout");
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk100);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic send_wait(input logic [7:0] b);
    send_byte(b);
    wait_ready("action_done_timeout");
  endtask

  task automatic do_reset(input bit check_zero);
    int low;
    low = 0;
    rst = 1'b1;
    @(negedge clk100);
    rst = 1'b0;
    if (check_zero) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_blit_en", blit_en, 0);
      check("rst_blit_start", blit_start, 0);
      check("rst_blit_end", blit_end, 0);
      check("rst_blit_offset", blit_offset, 0);
      check("rst_cursor_col", cursor_col, 0);
      check("rst_cursor_row", cursor_row, 0);
    end
    while (!rx_ready && low < RST_WAIT + 100) begin low++; @(negedge clk100); end
    check("rst_hold_cycles", low, RST_WAIT);
  endtask

  initial begin
    #2000000;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL watchdog: got timeout expected test end");
      finish_test();
    end
  end

  initial begin
    int base, n;
    do_reset(1'b0);

    send_wait(8'h41);
    check("first_wr_addr", last_wr_addr, 0);
    check("first_wr_data", last_wr_data, 'h41);
    check("first_wr_count", wr_cnt, 1);
    check("first_col", cursor_col, 1);

    base = blit_cnt;
    send_wait(8'h0C);
    check("ff_blit_count", blit_cnt - base, 1);
    check("ff_blit_start", lb_s, 0);
    check("ff_blit_end", lb_e, 2000);
    check("ff_blit_offset", lb_o, 0);
    check("ff_ready", rx_ready, 1);
    check("ff_col", cursor_col, 0);
    check("ff_row", cursor_row, 0);

    for (int i = 0; i < 80; i++) send_byte(8'h58);
    send_wait(8'h42);
    check("wrap_wr_addr", last_wr_addr, 80);
    check("wrap_wr_data", last_wr_data, 'h42);
    check("wrap_row", cursor_row, 1);
    check("wrap_col", cursor_col, 1);

    for (int i = 0; i < 23; i++) send_byte(8'h0A);
    wait_ready("lf_walk");
    check("lf_walk_row", cursor_row, 24);
    base = blit_cnt;
    send_wait(8'h0A);
    check("scroll_blit_count", blit_cnt - base, 2);
    check("scroll_copy_start", pb_s, 0);
    check("scroll_copy_end", pb_e, 1920);
    check("scroll_copy_offset", pb_o, 79);
    check("scroll_clear_start", lb_s, 1920);
    check("scroll_clear_end", lb_e, 2000);
    check("scroll_clear_offset", lb_o, 0);
    check("scroll_row", cursor_row, 24);
    check("scroll_col", cursor_col, 1);

    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) send_byte(8'h20);
    wait_ready("tab_setup");
    check("tab_pre_col", cursor_col, 3);
    send_wait(8'h09);
    check("tab_col3", cursor_col, 8);
    send_byte(8'h0D);
    for (int i = 0; i < 9; i++) send_byte(8'h09);
    for (int i = 0; i < 6; i++) send_byte(8'h20);
    wait_ready("tab78_setup");
    check("tab_pre_col78", cursor_col, 78);
    send_wait(8'h09);
    check("tab_col78", cursor_col, 79);
    send_byte(8'h0D);
    wait_ready("bs_setup");
    base = wr_cnt;
    send_wait(8'h08);
    check("bs_col0", cursor_col, 0);
    check("bs_no_write", wr_cnt - base, 0);

    for (int i = 0; i < 10; i++) send_byte(8'h09);
    base = blit_cnt;
    send_wait(8'h5A);
    check("last_cell_addr", last_wr_addr, 1999);
    check("last_cell_blits", blit_cnt - base, 2);
    check("last_cell_row", cursor_row, 24);
    check("last_cell_col", cursor_col, 0);

    spurious = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      rx_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 15))
        0, 1, 2: rx_data = 8'h0A;
        3:       rx_data = 8'h0D;
        4:       rx_data = 8'h08;
        5:       rx_data = 8'h09;
        6:       rx_data = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h41;
        7:       rx_data = 8'($urandom);
        default: rx_data = 8'($urandom_range(32, 126));
      endcase
      @(negedge clk100);
    end
    rx_valid = 1'b0;
    spurious = 1'b0;
    wait_ready("random_drain");

    for (int i = 0; i < 25; i++) send_byte(8'h0A);
    wait_ready("abort_setup");
    auto_cpl = 1'b0;
    base = blit_cnt;
    send_byte(8'h0A);
    n = 0;
    while (blit_cnt == base && n < 50) begin @(negedge clk100); n++; end
    check("abort_copy_issued", blit_cnt - base, 1);
    repeat (3) @(negedge clk100);
    check("abort_waiting_ready", rx_ready, 0);
    do_reset(1'b1);
    auto_cpl = 1'b1;
    send_wait(8'h41);
    check("post_abort_wr_addr", last_wr_addr, 0);
    check("post_abort_col", cursor_col, 1);

    finish_test();
  end

endmodule
